// File: rtl/cp_dmem_resp.sv
// Data-memory responder for the core's load/store port.
// Word-organised SRAM model with a fixed-latency, fully pipelined read-return path.
// Optional feature macro: CP_DMEM_ERR_EN adds data_err_o, flagging out-of-range accesses.
module cp_dmem_resp #(
  parameter int unsigned MEM_WORDS    = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_waddr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [31:0] data_raddr_i,
  output logic [31:0] data_rdata_o,
  output logic        data_rvalid_o
`ifdef CP_DMEM_ERR_EN
  ,
  output logic        data_err_o
`endif
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS) * 32'd4;

  // Reject illegal configurations at elaboration.
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $fatal(1, "cp_dmem_resp: READ_LATENCY must be in 1..4");
  end
  if (MEM_WORDS < 16 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
    $fatal(1, "cp_dmem_resp: MEM_WORDS must be a power of two >= 16");
  end

  logic [31:0] mem_q [MEM_WORDS];

  logic [31:0]   woff, roff;
  logic          wr_in_range, rd_in_range;
  logic [AW-1:0] widx, ridx;
  logic          wr_req, rd_req;
  logic [31:0]   rd_data;

  // Address decode: unsigned 32-bit offset, so addresses below the base wrap out of range.
  always_comb begin
    woff        = data_waddr_i - BASE_ADDR;
    roff        = data_raddr_i - BASE_ADDR;
    wr_in_range = (woff < MEM_BYTES);
    rd_in_range = (roff < MEM_BYTES);
    widx        = woff[AW+1:2];
    ridx        = roff[AW+1:2];
    wr_req      = data_req_i & data_we_i;
    rd_req      = data_req_i & ~data_we_i;
    rd_data     = rd_in_range ? mem_q[ridx] : 32'h0000_0000;
  end

  // Byte-lane offsets and bits above the array size do not select a word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{woff[1:0], roff[1:0], woff[31:AW+2], roff[31:AW+2]};

  // Byte-enabled array write; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_req && wr_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem_q[widx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  logic [READ_LATENCY-1:0] vld_q;
  logic [31:0]             data_q [READ_LATENCY];

  // Read-return shift register; data stages load only behind a valid so the output holds
  // its last response while idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_req;
      if (rd_req) begin
        data_q[0] <= rd_data;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign data_rvalid_o = vld_q[READ_LATENCY-1];
  assign data_rdata_o  = data_q[READ_LATENCY-1];

`ifdef CP_DMEM_ERR_EN
  logic [READ_LATENCY-1:0] err_q;
  logic                    err_in;

  // Out-of-range flag for either access type; writes ride along with valid = 0.
  always_comb begin
    err_in = data_req_i & (data_we_i ? ~wr_in_range : ~rd_in_range);
  end

  // Error bits shift in lockstep with the valid bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= '0;
    end else begin
      err_q[0] <= err_in;
      for (int i = 1; i < READ_LATENCY; i++) begin
        err_q[i] <= err_q[i-1];
      end
    end
  end

  assign data_err_o = err_q[READ_LATENCY-1];
`endif

endmodule

// File: tb/tb_cp_dmem_resp.sv
// Directed bench for cp_dmem_resp: one instance at READ_LATENCY = 1 (default size),
// one at READ_LATENCY = 3 with a 16-word array.
module tb_cp_dmem_resp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        a_req, a_we;
  logic [3:0]  a_be;
  logic [31:0] a_waddr, a_wdata, a_raddr, a_rdata;
  logic        a_rvalid;
  logic        b_req, b_we;
  logic [3:0]  b_be;
  logic [31:0] b_waddr, b_wdata, b_raddr, b_rdata;
  logic        b_rvalid;
`ifdef CP_DMEM_ERR_EN
  logic        a_err, b_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cp_dmem_resp u_l1 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .data_req_i   (a_req),
    .data_we_i    (a_we),
    .data_be_i    (a_be),
    .data_waddr_i (a_waddr),
    .data_wdata_i (a_wdata),
    .data_raddr_i (a_raddr),
    .data_rdata_o (a_rdata),
    .data_rvalid_o(a_rvalid)
`ifdef CP_DMEM_ERR_EN
    ,
    .data_err_o   (a_err)
`endif
  );

  cp_dmem_resp #(
    .MEM_WORDS   (16),
    .READ_LATENCY(3)
  ) u_l3 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .data_req_i   (b_req),
    .data_we_i    (b_we),
    .data_be_i    (b_be),
    .data_waddr_i (b_waddr),
    .data_wdata_i (b_wdata),
    .data_raddr_i (b_raddr),
    .data_rdata_o (b_rdata),
    .data_rvalid_o(b_rvalid)
`ifdef CP_DMEM_ERR_EN
    ,
    .data_err_o   (b_err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_set(input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] data);
    a_req = req; a_we = we; a_be = be; a_waddr = addr; a_raddr = addr; a_wdata = data;
  endtask

  task automatic b_set(input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] data);
    b_req = req; b_we = we; b_be = be; b_waddr = addr; b_raddr = addr; b_wdata = data;
  endtask

  initial begin
    a_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    b_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_a_rdata", a_rdata, 32'h0);
    chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    chk("rst_b_rdata", b_rdata, 32'h0);
`ifdef CP_DMEM_ERR_EN
    chk("rst_a_err", 32'(a_err), 32'd0);
    chk("rst_b_err", 32'(b_err), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Full write then read-back, latency 1.
    a_set(1'b1, 1'b1, 4'hF, 32'h0001_0010, 32'hDEAD_BEEF);
    tick();
    chk("wr_no_rvalid", 32'(a_rvalid), 32'd0);
    a_set(1'b1, 1'b0, 4'h0, 32'h0001_0010, 32'h0);
    tick();
    chk("rd1_rvalid", 32'(a_rvalid), 32'd1);
    chk("rd1_rdata", a_rdata, 32'hDEAD_BEEF);
    a_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("idle_rvalid", 32'(a_rvalid), 32'd0);

    // Partial write with be = 0101.
    a_set(1'b1, 1'b1, 4'hF, 32'h0001_0020, 32'h1122_3344);
    tick();
    a_set(1'b1, 1'b1, 4'b0101, 32'h0001_0020, 32'hAABB_CCDD);
    tick();
    a_set(1'b1, 1'b0, 4'h0, 32'h0001_0020, 32'h0);
    tick();
    chk("part_rvalid", 32'(a_rvalid), 32'd1);
    chk("part_rdata", a_rdata, 32'h11BB_33DD);

    // Write in cycle N visible in N+1; be = 0 write is a no-op.
    a_set(1'b1, 1'b1, 4'hF, 32'h0001_0014, 32'h5555_AAAA);
    tick();
    a_set(1'b1, 1'b0, 4'h0, 32'h0001_0014, 32'h0);
    tick();
    chk("raw_rdata", a_rdata, 32'h5555_AAAA);
    a_set(1'b1, 1'b1, 4'h0, 32'h0001_0014, 32'hFFFF_FFFF);
    tick();
    chk("be0_no_rvalid", 32'(a_rvalid), 32'd0);
    a_set(1'b1, 1'b0, 4'h0, 32'h0001_0014, 32'h0);
    tick();
    chk("be0_rvalid", 32'(a_rvalid), 32'd1);
    chk("be0_rdata", a_rdata, 32'h5555_AAAA);

    // Out-of-range accesses.
    a_set(1'b1, 1'b1, 4'hF, 32'h0000_0000, 32'hFFFF_FFFF);
    tick();
    chk("oor_wr_rvalid", 32'(a_rvalid), 32'd0);
`ifdef CP_DMEM_ERR_EN
    chk("oor_wr_err", 32'(a_err), 32'd1);
`endif
    a_set(1'b1, 1'b0, 4'h0, 32'h0000_FFFC, 32'h0);
    tick();
    chk("oor_lo_rvalid", 32'(a_rvalid), 32'd1);
    chk("oor_lo_rdata", a_rdata, 32'h0);
`ifdef CP_DMEM_ERR_EN
    chk("oor_lo_err", 32'(a_err), 32'd1);
`endif
    a_set(1'b1, 1'b0, 4'h0, 32'h0001_4000, 32'h0);
    tick();
    chk("oor_hi_rvalid", 32'(a_rvalid), 32'd1);
    chk("oor_hi_rdata", a_rdata, 32'h0);
`ifdef CP_DMEM_ERR_EN
    chk("oor_hi_err", 32'(a_err), 32'd1);
`endif
    a_set(1'b1, 1'b0, 4'h0, 32'h0001_0010, 32'h0);
    tick();
    chk("oor_keep_w4", a_rdata, 32'hDEAD_BEEF);
`ifdef CP_DMEM_ERR_EN
    chk("inr_err", 32'(a_err), 32'd0);
`endif
    a_set(1'b1, 1'b0, 4'h0, 32'h0001_0020, 32'h0);
    tick();
    chk("oor_keep_w8", a_rdata, 32'h11BB_33DD);
    a_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();

    // Latency 3: preload words 0..3, then four back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      b_set(1'b1, 1'b1, 4'hF, 32'h0001_0000 + 32'(4 * i), 32'hA0 + 32'(i));
      tick();
      chk("l3_wr_no_rvalid", 32'(b_rvalid), 32'd0);
    end
    b_set(1'b1, 1'b0, 4'h0, 32'h0001_0000, 32'h0);
    tick();
    chk("l3_c1_rvalid", 32'(b_rvalid), 32'd0);
    b_set(1'b1, 1'b0, 4'h0, 32'h0001_0004, 32'h0);
    tick();
    chk("l3_c2_rvalid", 32'(b_rvalid), 32'd0);
    b_set(1'b1, 1'b0, 4'h0, 32'h0001_0008, 32'h0);
    tick();
    chk("l3_c3_rvalid", 32'(b_rvalid), 32'd1);
    chk("l3_c3_rdata", b_rdata, 32'hA0);
    b_set(1'b1, 1'b0, 4'h0, 32'h0001_000C, 32'h0);
    tick();
    chk("l3_c4_rvalid", 32'(b_rvalid), 32'd1);
    chk("l3_c4_rdata", b_rdata, 32'hA1);
    b_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("l3_c5_rvalid", 32'(b_rvalid), 32'd1);
    chk("l3_c5_rdata", b_rdata, 32'hA2);
    tick();
    chk("l3_c6_rvalid", 32'(b_rvalid), 32'd1);
    chk("l3_c6_rdata", b_rdata, 32'hA3);
    tick();
    chk("l3_c7_rvalid", 32'(b_rvalid), 32'd0);

    // Latency 3: upper bound of a 16-word array.
    b_set(1'b1, 1'b0, 4'h0, 32'h0001_0040, 32'h0);
    tick();
    b_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    tick();
    chk("l3_oor_rvalid", 32'(b_rvalid), 32'd1);
    chk("l3_oor_rdata", b_rdata, 32'h0);
`ifdef CP_DMEM_ERR_EN
    chk("l3_oor_err", 32'(b_err), 32'd1);
`endif
    tick();

    // Reset with reads in flight: responses are dropped, memory kept.
    b_set(1'b1, 1'b1, 4'hF, 32'h0001_001C, 32'h7777_7777);
    tick();
    b_set(1'b1, 1'b0, 4'h0, 32'h0001_0000, 32'h0);
    tick();
    b_set(1'b1, 1'b0, 4'h0, 32'h0001_0004, 32'h0);
    tick();
    b_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("inrst_rvalid", 32'(b_rvalid), 32'd0);
    chk("inrst_rdata", b_rdata, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_rvalid", 32'(b_rvalid), 32'd0);
    end
    b_set(1'b1, 1'b0, 4'h0, 32'h0001_001C, 32'h0);
    tick();
    b_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    tick();
    chk("keep_rvalid", 32'(b_rvalid), 32'd1);
    chk("keep_rdata", b_rdata, 32'h7777_7777);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
